rom_load_seq: RTL and testbench

ROM_LOAD_SEQ -- requirements
Module: rom_load_seq

---
 rtl/rom_load_seq.sv | 151 +++++++++++++++
 tb/tb_rom_load_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rom_load_seq.sv
// ============================================================================
// rom_load_seq -- host ROM download sequencer: program/graphics write steering
// with stall, post-load game reset hold. Option: ROM_LOAD_SEQ_CHECKSUM_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rom_load_seq #(
   parameter int PROG_BYTES = 8192,
   parameter int GFX_BYTES  = 4096,
   parameter int WR_CYCLES  = 2,
   parameter int RST_HOLD   = 16
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [7:0]  ioctl_index,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_wait,
   output logic [12:0] rom_addr,
   output logic [7:0]  rom_data,
   output logic        prog_we,
   output logic        gfx_we,
   output logic        game_reset,
   output logic        load_done,
   output logic        load_err,
`ifdef ROM_LOAD_SEQ_CHECKSUM_EN
   output logic [7:0]  checksum,
`endif
   output logic [15:0] byte_count
);

   typedef enum logic [2:0] {
      BOOT  = 3'd0,
      LOAD  = 3'd1,
      WRITE = 3'd2,
      HOLD  = 3'd3,
      RUN   = 3'd4
   } state_t;

   localparam logic [24:0] PROG_LIMIT = 25'(PROG_BYTES);
   localparam logic [24:0] ROM_LIMIT  = 25'(PROG_BYTES + GFX_BYTES);
   localparam logic [12:0] GFX_BASE   = 13'(PROG_BYTES);
   localparam logic [3:0]  WAIT_LOAD  = 4'(WR_CYCLES - 1);
   localparam logic [7:0]  HOLD_LOAD  = 8'(RST_HOLD - 1);

   state_t      state;
   logic [3:0]  wait_cnt;
   logic [7:0]  hold_cnt;

   logic wr_idx0, start, in_range, in_prog, accept, restart;
   assign wr_idx0  = ioctl_wr && (ioctl_index == 8'd0);
   assign start    = ioctl_download && (ioctl_index == 8'd0);
   assign in_range = ioctl_addr < ROM_LIMIT;
   assign in_prog  = ioctl_addr < PROG_LIMIT;
   assign accept   = (state == LOAD) && ioctl_download && wr_idx0 && in_range;
   assign restart  = start && ((state == BOOT) || (state == RUN));

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state      <= BOOT;
         wait_cnt   <= 4'd0;
         hold_cnt   <= 8'd0;
         ioctl_wait <= 1'b0;
         rom_addr   <= 13'd0;
         rom_data   <= 8'd0;
         prog_we    <= 1'b0;
         gfx_we     <= 1'b0;
         game_reset <= 1'b1;
         load_done  <= 1'b0;
         load_err   <= 1'b0;
         byte_count <= 16'd0;
      end else begin
         prog_we <= 1'b0;
         gfx_we  <= 1'b0;
         case (state)
            BOOT, RUN: begin
               if (restart) begin
                  state      <= LOAD;
                  game_reset <= 1'b1;
                  load_done  <= 1'b0;
                  load_err   <= 1'b0;
                  byte_count <= 16'd0;
               end
            end
            LOAD: begin
               if (!ioctl_download) begin
                  state    <= HOLD;
                  hold_cnt <= HOLD_LOAD;
               end else if (wr_idx0) begin
                  if (in_range) begin
                     state      <= WRITE;
                     wait_cnt   <= WAIT_LOAD;
                     ioctl_wait <= 1'b1;
                     rom_data   <= ioctl_dout;
                     prog_we    <= in_prog;
                     gfx_we     <= !in_prog;
                     rom_addr   <= in_prog ? ioctl_addr[12:0] : ioctl_addr[12:0] - GFX_BASE;
                     if (byte_count != 16'hFFFF)
                        byte_count <= byte_count + 16'd1;
                  end else begin
                     load_err <= 1'b1;
                  end
               end
            end
            WRITE: begin
               // Strobes arriving while stalled are lost; flag them.
               if (wr_idx0)
                  load_err <= 1'b1;
               if (wait_cnt == 4'd0) begin
                  ioctl_wait <= 1'b0;
                  if (ioctl_download) begin
                     state <= LOAD;
                  end else begin
                     state    <= HOLD;
                     hold_cnt <= HOLD_LOAD;
                  end
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            HOLD: begin
               if (hold_cnt == 8'd0) begin
                  state      <= RUN;
                  game_reset <= 1'b0;
                  load_done  <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt - 8'd1;
               end
            end
            default: state <= BOOT;
         endcase
      end
   end

`ifdef ROM_LOAD_SEQ_CHECKSUM_EN
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset)
         checksum <= 8'd0;
      else if (restart)
         checksum <= 8'd0;
      else if (accept)
         checksum <= checksum + ioctl_dout;
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rom_load_seq.sv
// ============================================================================
// tb_rom_load_seq -- directed self-checking bench for rom_load_seq.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rom_load_seq;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        ioctl_download, ioctl_wr;
   logic [7:0]  ioctl_index, ioctl_dout;
   logic [24:0] ioctl_addr;
   logic        ioctl_wait, prog_we, gfx_we, game_reset, load_done, load_err;
   logic [12:0] rom_addr;
   logic [7:0]  rom_data;
   logic [15:0] byte_count;
`ifdef ROM_LOAD_SEQ_CHECKSUM_EN
   logic [7:0]  checksum;
`endif

   int errors = 0;
   int checks = 0;
   int we_seen;

   always #5 clk_sys = ~clk_sys;

   rom_load_seq dut (
      .clk_sys(clk_sys), .reset(reset),
      .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
      .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
      .ioctl_wait(ioctl_wait), .rom_addr(rom_addr), .rom_data(rom_data),
      .prog_we(prog_we), .gfx_we(gfx_we), .game_reset(game_reset),
      .load_done(load_done), .load_err(load_err),
`ifdef ROM_LOAD_SEQ_CHECKSUM_EN
      .checksum(checksum),
`endif
      .byte_count(byte_count)
   );

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One-clock strobe; returns just after the edge that sampled it.
   task automatic strobe(input logic [24:0] a, input logic [7:0] d);
      ioctl_wr   = 1'b1;
      ioctl_addr = a;
      ioctl_dout = d;
      tick();
      ioctl_wr   = 1'b0;
   endtask

   initial begin
      reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0;
      ioctl_index = 8'd0; ioctl_addr = 25'd0; ioctl_dout = 8'd0;
      repeat (3) tick();
      chk("rst_game_reset", {31'd0, game_reset}, 32'd1);
      chk("rst_load_done",  {31'd0, load_done},  32'd0);
      chk("rst_wait",       {31'd0, ioctl_wait}, 32'd0);
      chk("rst_we",         {30'd0, prog_we, gfx_we}, 32'd0);
      chk("rst_err",        {31'd0, load_err},   32'd0);
      chk("rst_count",      {16'd0, byte_count}, 32'd0);
      chk("rst_addr_data",  {11'd0, rom_addr, rom_data}, 32'd0);

      reset = 1'b0;
      we_seen = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (prog_we || gfx_we) we_seen++;
      end
      chk("idle_game_reset", {31'd0, game_reset}, 32'd1);
      chk("idle_load_done",  {31'd0, load_done},  32'd0);
      chk("idle_no_we",      we_seen, 32'd0);

      ioctl_download = 1'b1;
      tick();
      strobe(25'h0005, 8'hA5);
      chk("w1_prog_we",  {31'd0, prog_we}, 32'd1);
      chk("w1_gfx_we",   {31'd0, gfx_we},  32'd0);
      chk("w1_addr",     {19'd0, rom_addr}, 32'h0005);
      chk("w1_data",     {24'd0, rom_data}, 32'hA5);
      chk("w1_wait_c1",  {31'd0, ioctl_wait}, 32'd1);
      chk("w1_count",    {16'd0, byte_count}, 32'd1);
      tick();
      chk("w1_we_off",   {31'd0, prog_we}, 32'd0);
      chk("w1_wait_c2",  {31'd0, ioctl_wait}, 32'd1);
      tick();
      chk("w1_wait_end", {31'd0, ioctl_wait}, 32'd0);

      strobe(25'h2003, 8'h3C);
      chk("w2_gfx_we",  {30'd0, prog_we, gfx_we}, 32'd1);
      chk("w2_addr",    {19'd0, rom_addr}, 32'h0003);
      chk("w2_data",    {24'd0, rom_data}, 32'h3C);
      chk("w2_count",   {16'd0, byte_count}, 32'd2);
      repeat (2) tick();

      strobe(25'h3000, 8'h99);
      chk("oor_no_we",  {30'd0, prog_we, gfx_we}, 32'd0);
      chk("oor_err",    {31'd0, load_err}, 32'd1);
      chk("oor_count",  {16'd0, byte_count}, 32'd2);
      chk("oor_wait",   {31'd0, ioctl_wait}, 32'd0);

      strobe(25'h1FFF, 8'h77);
      chk("w3_prog_edge", {30'd0, prog_we, gfx_we}, 32'd2);
      chk("w3_addr",      {19'd0, rom_addr}, 32'h1FFF);
      chk("w3_count",     {16'd0, byte_count}, 32'd3);
      repeat (2) tick();

      ioctl_download = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tick();
         chk("hold_game_reset", {31'd0, game_reset}, 32'd1);
      end
      tick();
      chk("run_game_reset", {31'd0, game_reset}, 32'd0);
      chk("run_load_done",  {31'd0, load_done},  32'd1);

      ioctl_download = 1'b1;
      tick();
      chk("reload_game_reset", {31'd0, game_reset}, 32'd1);
      chk("reload_load_done",  {31'd0, load_done},  32'd0);
      chk("reload_count",      {16'd0, byte_count}, 32'd0);
      chk("reload_err_clr",    {31'd0, load_err},   32'd0);

      ioctl_index = 8'd1;
      strobe(25'h0002, 8'h44);
      chk("idx1_no_we",  {30'd0, prog_we, gfx_we}, 32'd0);
      chk("idx1_no_err", {31'd0, load_err}, 32'd0);
      chk("idx1_count",  {16'd0, byte_count}, 32'd0);
      ioctl_index = 8'd0;

      ioctl_wr = 1'b1; ioctl_addr = 25'h0000; ioctl_dout = 8'h11;
      tick();
      ioctl_addr = 25'h0001; ioctl_dout = 8'h22;
      tick();
      ioctl_wr = 1'b0;
      chk("drop_no_we", {30'd0, prog_we, gfx_we}, 32'd0);
      chk("drop_err",   {31'd0, load_err}, 32'd1);
      chk("drop_count", {16'd0, byte_count}, 32'd1);
      tick();
      chk("drop_wait_end", {31'd0, ioctl_wait}, 32'd0);

`ifdef ROM_LOAD_SEQ_CHECKSUM_EN
      reset = 1'b1;
      tick();
      chk("cks_rst", {24'd0, checksum}, 32'd0);
      reset = 1'b0;
      tick();
      strobe(25'h0010, 8'hFF); repeat (2) tick();
      strobe(25'h0011, 8'h02); repeat (2) tick();
      strobe(25'h2000, 8'h10); repeat (2) tick();
      chk("cks_sum", {24'd0, checksum}, 32'h11);
`endif

      strobe(25'h0004, 8'h55);
      chk("mid_we_before", {31'd0, prog_we}, 32'd1);
      reset = 1'b1;
      ioctl_download = 1'b0;
      #1;
      chk("mid_async_we",   {30'd0, prog_we, gfx_we}, 32'd0);
      chk("mid_async_wait", {31'd0, ioctl_wait}, 32'd0);
      chk("mid_async_gr",   {31'd0, game_reset}, 32'd1);
      tick();
      reset = 1'b0;
      we_seen = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (prog_we || gfx_we || ioctl_wait) we_seen++;
      end
      chk("mid_no_pulse",  we_seen, 32'd0);
      chk("mid_boot_gr",   {31'd0, game_reset}, 32'd1);
      chk("mid_boot_done", {31'd0, load_done},  32'd0);
      chk("mid_count",     {16'd0, byte_count}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
